// File: rtl/ton_bank_scheduler_if.sv
// Bus bundle for the TON timer bank: rung enables, PRE config port,
// ACC readback and per-channel status vectors.
interface ton_bank_scheduler_if #(
  parameter int NUM_TIMERS = 8,
  parameter int IDX_W      = 3
);
  logic [NUM_TIMERS-1:0] in_vec;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_idx;
  logic [31:0]           cfg_pre;
  logic [IDX_W-1:0]      rd_idx;
  logic [31:0]           rd_acc;
  logic [NUM_TIMERS-1:0] en_vec;
  logic [NUM_TIMERS-1:0] dn_vec;
  logic [NUM_TIMERS-1:0] tt_vec;
  logic                  tick_out;
  logic                  busy;
  logic                  overrun;

  modport master (
    output in_vec, cfg_we, cfg_idx, cfg_pre, rd_idx,
    input  rd_acc, en_vec, dn_vec, tt_vec, tick_out, busy, overrun
  );

  modport slave (
    input  in_vec, cfg_we, cfg_idx, cfg_pre, rd_idx,
    output rd_acc, en_vec, dn_vec, tt_vec, tick_out, busy, overrun
  );
endinterface

// File: rtl/ton_bank_scheduler.sv
// Time-multiplexed bank of on-delay timers: a 1 ms prescaler launches a sweep
// that updates one channel per cycle through a single shared incrementer.
module ton_bank_scheduler #(
  parameter int NUM_TIMERS = 8,
  parameter int IDX_W      = 3,
  parameter int CLK_DIV    = 50000
) (
  input  logic clk,
  input  logic rst,
  ton_bank_scheduler_if.slave bus
);
  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TIMERS - 1);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      prescale_q;
  logic                  overrun_q;
  logic [31:0]           acc_q [NUM_TIMERS];
  logic [31:0]           pre_q [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] en_q, dn_q, tt_q;
  logic                  tick;
  logic [31:0]           curAcc, curPre, newAcc, rdAcc;
  logic                  newDn;

  assign tick = (prescale_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q <= '0;
    end else if (tick) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_q + CNT_W'(1);
    end
  end

  // A tick only launches a sweep from IDLE; ticks seen mid-sweep are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (tick && (state_q == SWEEP)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Shared saturating incrementer for the channel under the sweep pointer.
  always_comb begin
    curAcc = '0;
    curPre = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        curAcc = acc_q[i];
        curPre = pre_q[i];
      end
    end
    newAcc = (curAcc < curPre) ? curAcc + 32'd1 : curAcc;
    newDn  = (newAcc >= curPre);
  end

  // Disable wins over a sweep update; PRE writes see the old value this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        acc_q[i] <= '0;
        pre_q[i] <= '0;
      end
      en_q <= '0;
      dn_q <= '0;
      tt_q <= '0;
    end else begin
      en_q <= bus.in_vec;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (!bus.in_vec[i]) begin
          acc_q[i] <= '0;
          dn_q[i]  <= 1'b0;
          tt_q[i]  <= 1'b0;
        end else if ((state_q == SWEEP) && (idx_q == IDX_W'(i))) begin
          acc_q[i] <= newAcc;
          dn_q[i]  <= newDn;
          tt_q[i]  <= ~newDn;
        end
        if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
          pre_q[i] <= bus.cfg_pre;
        end
      end
    end
  end

  always_comb begin
    rdAcc = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (bus.rd_idx == IDX_W'(i)) begin
        rdAcc = acc_q[i];
      end
    end
  end

  assign bus.rd_acc   = rdAcc;
  assign bus.en_vec   = en_q;
  assign bus.dn_vec   = dn_q;
  assign bus.tt_vec   = tt_q;
  assign bus.tick_out = tick;
  assign bus.busy     = (state_q == SWEEP);
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_ton_bank_scheduler.sv
// Randomized self-checking bench for ton_bank_scheduler: a 4-channel bank and a
// 3-channel bank whose tick period forces overrun, both against a cycle-count model.
module tb_ton_bank_scheduler;
  localparam int NA = 4;
  localparam int DA = 8;
  localparam int NB = 3;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ton_bank_scheduler_if #(.NUM_TIMERS(NA), .IDX_W(2)) ifA ();
  ton_bank_scheduler_if #(.NUM_TIMERS(NB), .IDX_W(2)) ifB ();

  ton_bank_scheduler #(.NUM_TIMERS(NA), .IDX_W(2), .CLK_DIV(DA)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  ton_bank_scheduler #(.NUM_TIMERS(NB), .IDX_W(2), .CLK_DIV(DB)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit pinPhase = 1'b0;

  // Model state, index 0 = bank A, index 1 = bank B
  int          nT [2] = '{NA, NB};
  int          dv [2] = '{DA, DB};
  logic [31:0] mAcc [2][4];
  logic [31:0] mPre [2][4];
  logic [3:0]  mEn [2];
  logic [3:0]  mDn [2];
  logic [3:0]  mTt [2];
  logic        mOvr [2];
  int          mStart [2];

  // Stimulus for the current cycle
  logic [3:0]  inV [2];
  logic        we [2];
  logic [1:0]  cIdx [2];
  logic [31:0] cPre [2];
  logic [1:0]  rIdx [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit tickAt(input int m, input int c);
    return (c % dv[m]) == dv[m] - 1;
  endfunction

  function automatic bit busyAt(input int m, input int c);
    return (mStart[m] >= 0) && (c >= mStart[m]) && (c < mStart[m] + nT[m]);
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        mAcc[m][k] = '0;
        mPre[m][k] = '0;
      end
      mEn[m]    = '0;
      mDn[m]    = '0;
      mTt[m]    = '0;
      mOvr[m]   = 1'b0;
      mStart[m] = -1;
    end
    cyc = 0;
  endtask

  // Advance one clock: channel k of a sweep starting at cycle s is updated at s+k.
  task automatic modelStep(input int m);
    bit          tk;
    bit          bz;
    int          s;
    logic [31:0] a;
    tk = tickAt(m, cyc);
    bz = busyAt(m, cyc);
    s  = mStart[m];
    for (int k = 0; k < nT[m]; k++) begin
      if (!inV[m][k]) begin
        mAcc[m][k] = '0;
        mDn[m][k]  = 1'b0;
        mTt[m][k]  = 1'b0;
      end else if (bz && (cyc - s == k)) begin
        a = mAcc[m][k];
        if (a < mPre[m][k]) a = a + 32'd1;
        mAcc[m][k] = a;
        mDn[m][k]  = (a >= mPre[m][k]);
        mTt[m][k]  = !(a >= mPre[m][k]);
      end
      mEn[m][k] = inV[m][k];
    end
    if (we[m] && (int'(cIdx[m]) < nT[m])) mPre[m][cIdx[m]] = cPre[m];
    if (tk && bz) mOvr[m] = 1'b1;
    if (tk && !bz) mStart[m] = cyc + 1;
  endtask

  task automatic checkAll();
    logic [31:0] expRd;
    expRd = (int'(rIdx[0]) < NA) ? mAcc[0][rIdx[0]] : 32'd0;
    checkOutput("A.rd_acc", ifA.rd_acc, expRd);
    checkOutput("A.en_vec", 32'(ifA.en_vec), 32'(mEn[0]));
    checkOutput("A.dn_vec", 32'(ifA.dn_vec), 32'(mDn[0]));
    checkOutput("A.tt_vec", 32'(ifA.tt_vec), 32'(mTt[0]));
    checkOutput("A.tick_out", 32'(ifA.tick_out), 32'(rst && tickAt(0, cyc)));
    checkOutput("A.busy", 32'(ifA.busy), 32'(busyAt(0, cyc)));
    checkOutput("A.overrun", 32'(ifA.overrun), 32'(mOvr[0]));
    expRd = (int'(rIdx[1]) < NB) ? mAcc[1][rIdx[1]] : 32'd0;
    checkOutput("B.rd_acc", ifB.rd_acc, expRd);
    checkOutput("B.en_vec", 32'(ifB.en_vec), 32'(mEn[1][2:0]));
    checkOutput("B.dn_vec", 32'(ifB.dn_vec), 32'(mDn[1][2:0]));
    checkOutput("B.tt_vec", 32'(ifB.tt_vec), 32'(mTt[1][2:0]));
    checkOutput("B.tick_out", 32'(ifB.tick_out), 32'(rst && tickAt(1, cyc)));
    checkOutput("B.busy", 32'(ifB.busy), 32'(busyAt(1, cyc)));
    checkOutput("B.overrun", 32'(ifB.overrun), 32'(mOvr[1]));
  endtask

  // Hand-derived values for the directed opening sequence after reset release
  task automatic pinModel();
    case (cyc)
      0:  checkOutput("pinA.en0", 32'(ifA.en_vec), 32'h0);
      1:  checkOutput("pinA.en1", 32'(ifA.en_vec), 32'h4);
      5:  checkOutput("pinB.ovr5", 32'(ifB.overrun), 32'h0);
      6: begin
        checkOutput("pinA.tick6", 32'(ifA.tick_out), 32'h0);
        checkOutput("pinB.ovr6", 32'(ifB.overrun), 32'h1);
        checkOutput("pinB.dn6", 32'(ifB.dn_vec), 32'h5);
        checkOutput("pinB.tt6", 32'(ifB.tt_vec), 32'h2);
      end
      7:  checkOutput("pinA.tick7", 32'(ifA.tick_out), 32'h1);
      8:  checkOutput("pinA.busy8", 32'(ifA.busy), 32'h1);
      10: checkOutput("pinA.acc10", ifA.rd_acc, 32'd0);
      11: begin
        checkOutput("pinA.acc11", ifA.rd_acc, 32'd1);
        checkOutput("pinA.tt11", 32'(ifA.tt_vec), 32'h4);
      end
      12: begin
        checkOutput("pinA.busy12", 32'(ifA.busy), 32'h0);
        checkOutput("pinB.acc12", ifB.rd_acc, 32'd2);
      end
      16: checkOutput("pinB.acc16", ifB.rd_acc, 32'd2);
      17: checkOutput("pinB.acc17", ifB.rd_acc, 32'd3);
      28: begin
        checkOutput("pinA.acc28", ifA.rd_acc, 32'd3);
        checkOutput("pinA.dn28", 32'(ifA.dn_vec), 32'h4);
        checkOutput("pinA.tt28", 32'(ifA.tt_vec), 32'h0);
      end
      44: checkOutput("pinA.acc44", ifA.rd_acc, 32'd3);
      default: ;
    endcase
  endtask

  // Called at a falling edge: drive, settle, compare, advance model, move to next falling edge.
  task automatic applyStimulus(input bit rnd);
    int r;
    if (rnd) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 4; k++) begin
          if (inV[m][k]) begin
            if ($urandom_range(0, 59) == 0) inV[m][k] = 1'b0;
          end else if ($urandom_range(0, 7) == 0) begin
            inV[m][k] = 1'b1;
          end
        end
        we[m]   = ($urandom_range(0, 9) == 0);
        cIdx[m] = 2'($urandom_range(0, 3));
        r       = int'($urandom_range(0, 9));
        if (r < 7)      cPre[m] = $urandom_range(0, 6);
        else if (r < 9) cPre[m] = 32'hFFFF_FFFF;
        else            cPre[m] = $urandom_range(0, 1);
        rIdx[m] = 2'($urandom_range(0, 3));
      end
    end
    ifA.in_vec  = inV[0];
    ifA.cfg_we  = we[0];
    ifA.cfg_idx = cIdx[0];
    ifA.cfg_pre = cPre[0];
    ifA.rd_idx  = rIdx[0];
    ifB.in_vec  = inV[1][2:0];
    ifB.cfg_we  = we[1];
    ifB.cfg_idx = cIdx[1];
    ifB.cfg_pre = cPre[1];
    ifB.rd_idx  = rIdx[1];
    #1;
    checkAll();
    if (pinPhase) pinModel();
    if (rst) begin
      modelStep(0);
      modelStep(1);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput("rst.statusA",
                  32'({ifA.en_vec, ifA.dn_vec, ifA.tt_vec, ifA.tick_out, ifA.busy, ifA.overrun}),
                  32'h0);
    end
    rst = 1'b1;
  endtask

  initial begin
    int waited;
    for (int m = 0; m < 2; m++) begin
      inV[m] = '0; we[m] = 1'b0; cIdx[m] = '0; cPre[m] = '0; rIdx[m] = '0;
    end
    @(negedge clk);
    doReset();

    // Directed opening: A counts channel 2 to PRE=3, B runs with ticks overrunning sweeps
    pinPhase = 1'b1;
    for (int i = 0; i < 48; i++) begin
      inV[0]  = 4'b0100;
      we[0]   = (cyc == 0);
      cIdx[0] = 2'd2;
      cPre[0] = 32'd3;
      rIdx[0] = 2'd2;
      inV[1]  = 4'b0111;
      we[1]   = (cyc <= 1);
      cIdx[1] = (cyc == 0) ? 2'd1 : 2'd3;
      cPre[1] = (cyc == 0) ? 32'd100 : 32'd7;
      rIdx[1] = 2'd1;
      applyStimulus(1'b0);
    end
    pinPhase = 1'b0;
    $display("[TB] directed phase done, checks=%0d", checks);

    for (int i = 0; i < 3000; i++) applyStimulus(1'b1);

    // Reset in the middle of a sweep of bank A
    waited = 0;
    while (!(busyAt(0, cyc) && (cyc - mStart[0] == 2)) && waited < 100) begin
      applyStimulus(1'b1);
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      failures++;
      $display("[TB] FAIL midSweepWait cyc=%0d got=timeout want=sweep", cyc);
    end
    doReset();

    for (int i = 0; i < 1000; i++) applyStimulus(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ton_bank_scheduler.md
Name: ton_bank_scheduler

Overview:
Time-multiplexed bank of NUM_TIMERS on-delay (TON) ladder timers. All channels share one 32-bit incrementer/comparator. An internal 1 ms prescaler generates the timing tick. On each tick, a scheduler FSM visits every channel once to update its accumulator and DN/TT status. This block replaces per-rung timer instances in the generated ladder top level; PRE values are loaded through a config write port.

Parameters:
NUM_TIMERS, 8, number of timer channels (≥1)
IDX_W, 3, channel index width; must satisfy 2**IDX_W ≥ NUM_TIMERS
CLK_DIV, 50000, clk cycles per 1 ms tick; must be ≥ NUM_TIMERS+1, otherwise overrun occurs

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
in_vec  in  NUM_TIMERS  per-channel rung enable (IN)
cfg_we  in  1  PRE write strobe
cfg_idx  in  IDX_W  PRE write channel
cfg_pre  in  32  PRE value in ms
rd_idx  in  IDX_W  ACC readback channel select
rd_acc  out  32  ACC of channel rd_idx; combinational read
en_vec  out  NUM_TIMERS  per-channel EN
dn_vec  out  NUM_TIMERS  per-channel DN
tt_vec  out  NUM_TIMERS  per-channel TT
tick_out  out  1  one-cycle pulse per ms tick
busy  out  1  high while the FSM is in SWEEP
overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset (rst low, async): prescaler=0, FSM=IDLE, sweep index=0; all ACC=0; all PRE=0; en/dn/tt vectors=0; tick_out=0, busy=0, overrun=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick_out=1 for the single cycle in which the count equals CLK_DIV-1.
  - First tick_out occurs in the CLK_DIV-th cycle after reset release.
- EN: en_vec[i] is registered from in_vec[i] every cycle (1-cycle latency), independent of the FSM.
- Disable (parallel, every cycle): when in_vec[i]=0, next cycle ACC[i]=0, dn[i]=0, tt[i]=0. Disable takes priority over a sweep update of the same channel in the same cycle.
- FSM states IDLE and SWEEP:
  - IDLE → SWEEP on tick_out, with idx=0.
  - SWEEP processes channel idx in that cycle; idx increments each cycle.
  - After idx=NUM_TIMERS-1 → IDLE.
  - busy=1 exactly while in SWEEP, i.e. NUM_TIMERS cycles starting the cycle after tick_out.
- Channel update (SWEEP, channel k, when in_vec[k]=1 in that cycle; uses the registered PRE[k] value current that cycle):
  - new_acc = (ACC[k] < PRE[k]) ? ACC[k]+1 : ACC[k].
  - dn[k] = (new_acc ≥ PRE[k]); tt[k] = ~dn[k].
  - Results are visible the cycle after processing, i.e. tick at cycle T makes channel k visible at T+2+k.
- Channel update when in_vec[k]=0 during SWEEP: the disable rule applies; no count.
- Arithmetic: ACC saturates at PRE and never wraps. If PRE is lowered below ACC, ACC holds its value (no decrement) and DN=1 at the next sweep. PRE=0 gives DN=1 at the first sweep with ACC=0.
- A newly enabled channel has tt=0, dn=0 until its first sweep.
- Config write:
  - cfg_we=1 with cfg_idx < NUM_TIMERS writes PRE[cfg_idx] at that clock edge.
  - A sweep reading the same channel in that cycle uses the old PRE.
  - cfg_idx ≥ NUM_TIMERS is ignored.
  - PRE writes never modify ACC.
- Overrun: tick_out while busy=1 sets overrun=1. That tick is dropped and the current sweep continues. overrun is cleared only by reset.
- rd_acc: rd_idx ≥ NUM_TIMERS returns 0.
- Reset mid-sweep: immediate return to the reset state; no partial state is retained.

Test Plan:
(All scenarios use NUM_TIMERS=4, IDX_W=2, CLK_DIV=8 unless noted.)
- Reset/prescaler: hold rst low, then release → all outputs 0; tick_out pulses at cycles 8, 16, 24…; busy high for 4 cycles after each tick.
- Count to done: PRE[2]=3, in_vec=4'b0100 → en_vec[2]=1 next cycle; after sweep 1 acc=1, tt=1; after sweep 3 acc=3, dn=1, tt=0; sweeps 4+ leave acc=3.
- Disable mid-count: with channel 2 at acc=2, drop in_vec[2], including in the cycle channel 2 is swept → next cycle acc=0, en/dn/tt=0; re-enable restarts from 0.
- Edge presets: PRE[0]=0 enabled → dn[0]=1, acc=0 after first sweep. PRE[1]=32'hFFFFFFFF → tt=1, acc increments by 1 per tick. Lower PRE[1] to 1 while acc=5 → acc holds 5, dn=1 next sweep. cfg write to idx 3 during its sweep cycle → old PRE used for that sweep.
- Overrun: CLK_DIV=4 → tick arrives during the first sweep's last cycle; overrun=1 and stays set; each channel's acc advances once per completed sweep only.
- Readback: rd_idx walks 0..3 → rd_acc matches the model; with NUM_TIMERS=3, rd_idx=3 → rd_acc=0, and a cfg write to idx 3 has no effect.
